// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types and constants for the multi-class parking-lot
//            controller: controller state encoding, the time-of-day schedule
//            for the class-0 quota, and the schedule lookup function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package parking_pkg;

  // Controller states. The FSM itself uses the fixed-width constants below.
  typedef enum logic [0:0] {
    CONFIG = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam logic [0:0] ST_CONFIG = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  // Width of the values returned by the schedule lookup.
  localparam int SCHED_QW = 11;

  // Schedule breakpoints (hour of day).
  localparam int SCHED_H_PEAK_LO = 9;
  localparam int SCHED_H_PEAK_HI = 12;
  localparam int SCHED_H_13      = 13;
  localparam int SCHED_H_14      = 14;
  localparam int SCHED_H_15      = 15;

  // Class-0 quota for each schedule band.
  localparam logic [SCHED_QW-1:0] SCHED_Q_PEAK = SCHED_QW'(200);
  localparam logic [SCHED_QW-1:0] SCHED_Q_13   = SCHED_QW'(250);
  localparam logic [SCHED_QW-1:0] SCHED_Q_14   = SCHED_QW'(300);
  localparam logic [SCHED_QW-1:0] SCHED_Q_15   = SCHED_QW'(350);
  localparam logic [SCHED_QW-1:0] SCHED_Q_OFF  = SCHED_QW'(500);

  // Class-0 quota for a given hour of day.
  function automatic logic [SCHED_QW-1:0] sched_quota(input logic [31:0] hour);
    logic [SCHED_QW-1:0] q;
    q = SCHED_Q_OFF;
    if (hour >= 32'(SCHED_H_PEAK_LO) && hour <= 32'(SCHED_H_PEAK_HI)) begin
      q = SCHED_Q_PEAK;
    end else if (hour == 32'(SCHED_H_13)) begin
      q = SCHED_Q_13;
    end else if (hour == 32'(SCHED_H_14)) begin
      q = SCHED_Q_14;
    end else if (hour == 32'(SCHED_H_15)) begin
      q = SCHED_Q_15;
    end
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_lot_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_multi_if
// Purpose  : Gate handshake bundle for the parking-lot controller: entry and
//            exit requests towards the controller, one-cycle result pulses
//            back to the gate logic.
// Signals  : ent_valid/ent_class  car at entry gate and its class
//            ext_valid/ext_class  car at exit gate and its class
//            ent_grant/ent_deny   entry result pulses
//            ext_err              exit from an empty (or unknown) class
// Modports : master = gate side, slave = controller side
// Revision : 1.0 - initial release
// ============================================================================
interface parking_lot_multi_if
  import parking_pkg::*;
#(
  parameter int NUM_CLASS = 2
);
  localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

  logic             ent_valid;
  logic [CLS_W-1:0] ent_class;
  logic             ext_valid;
  logic [CLS_W-1:0] ext_class;
  logic             ent_grant;
  logic             ent_deny;
  logic             ext_err;

  modport master (
    output ent_valid, ent_class, ext_valid, ext_class,
    input  ent_grant, ent_deny, ext_err
  );

  modport slave (
    input  ent_valid, ent_class, ext_valid, ext_class,
    output ent_grant, ent_deny, ext_err
  );

endinterface
`default_nettype wire

// File: rtl/parking_class_cnt.sv
`default_nettype none
// ============================================================================
// Module   : parking_class_cnt
// Purpose  : Per-class occupancy counter and quota register. Provides the
//            registered count/quota plus the next-cycle count and quota
//            headroom so the parent can register its status outputs in step
//            with the counter.
// Ports    : clk, rst_n              clock, synchronous active-low reset
//            load/load_quota/load_occ configuration write (highest priority)
//            quota_we/quota_in        quota overwrite (schedule)
//            inc/dec                  one-car increment / decrement
//            occ/quota                registered count and quota
//            occ_nxt/headroom_nxt     next count, next saturated quota-occ
// Revision : 1.0 - initial release
// ============================================================================
module parking_class_cnt
  import parking_pkg::*;
#(
  parameter int CNT_W     = 11,
  parameter int DEF_QUOTA = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_quota,
  input  logic [CNT_W-1:0] load_occ,
  input  logic             quota_we,
  input  logic [CNT_W-1:0] quota_in,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occ,
  output logic [CNT_W-1:0] quota,
  output logic [CNT_W-1:0] occ_nxt,
  output logic [CNT_W-1:0] headroom_nxt
);

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] quota_q, quota_d;

  always_comb begin
    occ_d   = occ_q;
    quota_d = quota_q;
    if (load) begin
      occ_d   = load_occ;
      quota_d = load_quota;
    end else begin
      if (quota_we) begin
        quota_d = quota_in;
      end
      // inc and dec together cancel out (exit and re-entry of the same class)
      if (inc && !dec) begin
        occ_d = occ_q + CNT_W'(1);
      end else if (dec && !inc) begin
        occ_d = occ_q - CNT_W'(1);
      end
    end
    // A quota drop below the current count saturates headroom at zero
    headroom_nxt = (quota_d > occ_d) ? (quota_d - occ_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= '0;
      quota_q <= CNT_W'(DEF_QUOTA);
    end else begin
      occ_q   <= occ_d;
      quota_q <= quota_d;
    end
  end

  assign occ     = occ_q;
  assign quota   = quota_q;
  assign occ_nxt = occ_d;

endmodule
`default_nettype wire

// File: rtl/parking_lot_multi.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_multi
// Purpose  : Multi-class parking-lot occupancy controller. NUM_CLASS classes
//            share MAX_CAP spaces, each limited by its own quota; the class-0
//            quota follows a time-of-day schedule in RUN. Entry and exit are
//            processed every cycle, exit first.
// Ports    : clk, rst_n        clock, synchronous active-low reset
//            in_out_time       current hour of day
//            cfg_we/cfg_class/cfg_quota/cfg_count/cfg_done  configuration
//            gate              entry/exit handshake (slave modport)
//            cfg_err           rejected configuration write pulse
//            occ/free          per-class count / available spaces (packed)
//            total_occ, full   lot totals
//            ready             controller in RUN
// Revision : 1.0 - initial release
// ============================================================================
module parking_lot_multi
  import parking_pkg::*;
#(
  parameter int NUM_CLASS = 2,
  parameter int CNT_W     = 11,
  parameter int MAX_CAP   = 700,
  parameter int TIME_W    = 5,
  parameter int DEF_QUOTA = 500,
  parameter bit SCHED_EN  = 1'b1,
  localparam int CLS_W    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TIME_W-1:0]          in_out_time,
  input  logic                       cfg_we,
  input  logic [CLS_W-1:0]           cfg_class,
  input  logic [CNT_W-1:0]           cfg_quota,
  input  logic [CNT_W-1:0]           cfg_count,
  input  logic                       cfg_done,
  parking_lot_multi_if.slave         gate,
  output logic                       cfg_err,
  output logic [NUM_CLASS*CNT_W-1:0] occ,
  output logic [NUM_CLASS*CNT_W-1:0] free,
  output logic [CNT_W-1:0]           total_occ,
  output logic                       full,
  output logic                       ready
);

  localparam int               SUM_W       = CNT_W + $clog2(NUM_CLASS + 1);
  localparam logic [CLS_W:0]   NUM_CLASS_V = (CLS_W + 1)'(NUM_CLASS);
  localparam logic [CNT_W-1:0] MAX_CAP_V   = CNT_W'(MAX_CAP);

  logic [0:0]       state_q, state_d;
  logic             ent_grant_q, ent_grant_d;
  logic             ent_deny_q, ent_deny_d;
  logic             ext_err_q, ext_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] total_occ_q, total_occ_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] free_q [NUM_CLASS];
  logic [CNT_W-1:0] free_d [NUM_CLASS];

  logic [CNT_W-1:0] cls_occ      [NUM_CLASS];
  logic [CNT_W-1:0] cls_quota    [NUM_CLASS];
  logic [CNT_W-1:0] cls_occ_nxt  [NUM_CLASS];
  logic [CNT_W-1:0] cls_head_nxt [NUM_CLASS];
  logic [NUM_CLASS-1:0] cls_load, cls_inc, cls_dec;

  logic [CNT_W-1:0] load_occ;
  logic [CNT_W-1:0] sched_quota_w;
  logic             sched_we;
  logic [SUM_W-1:0] other_sum;
  logic             cfg_in_range, ent_in_range, ext_in_range;
  logic             ext_ok, ent_ok;
  logic [CNT_W-1:0] occ_post, total_post, cap_left;

  assign sched_quota_w = CNT_W'(sched_quota(32'(in_out_time)));
  assign sched_we      = SCHED_EN && (state_q == ST_RUN);
  assign cfg_in_range  = {1'b0, cfg_class} < NUM_CLASS_V;
  assign ent_in_range  = {1'b0, gate.ent_class} < NUM_CLASS_V;
  assign ext_in_range  = {1'b0, gate.ext_class} < NUM_CLASS_V;

  // Event handling and FSM
  always_comb begin
    state_d     = state_q;
    cls_load    = '0;
    cls_inc     = '0;
    cls_dec     = '0;
    load_occ    = cfg_count;
    cfg_err_d   = 1'b0;
    ent_grant_d = 1'b0;
    ent_deny_d  = 1'b0;
    ext_err_d   = 1'b0;
    ext_ok      = 1'b0;
    ent_ok      = 1'b0;
    occ_post    = '0;
    total_post  = '0;
    other_sum   = '0;

    // Occupancy of every class except the one being configured
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (c != int'(cfg_class)) begin
        other_sum = other_sum + SUM_W'(cls_occ[c]);
      end
    end

    if (state_q == ST_CONFIG) begin
      if (cfg_we) begin
        if (!cfg_in_range) begin
          cfg_err_d = 1'b1;
        end else begin
          cls_load[cfg_class] = 1'b1;
          // Rejected writes still take the quota but clear the count
          if ((cfg_count > cfg_quota) ||
              ((other_sum + SUM_W'(cfg_count)) > SUM_W'(MAX_CAP))) begin
            load_occ  = '0;
            cfg_err_d = 1'b1;
          end
        end
      end
      if (cfg_done) begin
        state_d = ST_RUN;
      end
    end else begin
      // Exit first, so a simultaneous entry sees the freed space
      if (gate.ext_valid) begin
        if (ext_in_range && (cls_occ[gate.ext_class] != '0)) begin
          ext_ok                 = 1'b1;
          cls_dec[gate.ext_class] = 1'b1;
        end else begin
          ext_err_d = 1'b1;
        end
      end
      if (gate.ent_valid) begin
        if (ent_in_range) begin
          occ_post   = cls_occ[gate.ent_class];
          total_post = total_occ_q;
          if (ext_ok) begin
            total_post = total_post - CNT_W'(1);
            if (gate.ext_class == gate.ent_class) begin
              occ_post = occ_post - CNT_W'(1);
            end
          end
          // free > 0 <=> below own quota and below the shared capacity
          ent_ok = (occ_post < cls_quota[gate.ent_class]) && (total_post < MAX_CAP_V);
        end
        if (ent_ok) begin
          cls_inc[gate.ent_class] = 1'b1;
          ent_grant_d             = 1'b1;
        end else begin
          ent_deny_d = 1'b1;
        end
      end
    end
  end

  // Status for the cycle after this edge, from the counters' next values
  always_comb begin
    total_occ_d = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      total_occ_d = total_occ_d + cls_occ_nxt[c];
    end
    cap_left = (total_occ_d >= MAX_CAP_V) ? '0 : (MAX_CAP_V - total_occ_d);
    full_d   = (total_occ_d == MAX_CAP_V);
    for (int c = 0; c < NUM_CLASS; c++) begin
      free_d[c] = (cls_head_nxt[c] < cap_left) ? cls_head_nxt[c] : cap_left;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CONFIG;
      ent_grant_q <= 1'b0;
      ent_deny_q  <= 1'b0;
      ext_err_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      total_occ_q <= '0;
      full_q      <= 1'b0;
      for (int c = 0; c < NUM_CLASS; c++) begin
        free_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ent_grant_q <= ent_grant_d;
      ent_deny_q  <= ent_deny_d;
      ext_err_q   <= ext_err_d;
      cfg_err_q   <= cfg_err_d;
      total_occ_q <= total_occ_d;
      full_q      <= full_d;
      for (int c = 0; c < NUM_CLASS; c++) begin
        free_q[c] <= free_d[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
    parking_class_cnt #(
      .CNT_W     (CNT_W),
      .DEF_QUOTA (DEF_QUOTA)
    ) u_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (cls_load[c]),
      .load_quota   (cfg_quota),
      .load_occ     (load_occ),
      .quota_we     ((c == 0) && sched_we),
      .quota_in     (sched_quota_w),
      .inc          (cls_inc[c]),
      .dec          (cls_dec[c]),
      .occ          (cls_occ[c]),
      .quota        (cls_quota[c]),
      .occ_nxt      (cls_occ_nxt[c]),
      .headroom_nxt (cls_head_nxt[c])
    );
    assign occ[c*CNT_W +: CNT_W]  = cls_occ[c];
    assign free[c*CNT_W +: CNT_W] = free_q[c];
  end

  assign gate.ent_grant = ent_grant_q;
  assign gate.ent_deny  = ent_deny_q;
  assign gate.ext_err   = ext_err_q;
  assign cfg_err        = cfg_err_q;
  assign total_occ      = total_occ_q;
  assign full           = full_q;
  assign ready          = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: doc/parking_lot_multi.md
Name: parking_lot_multi

Overview:
- Multi-class parking-lot occupancy controller; next generation of the two-class (uni/general) lot controller.
- Supports NUM_CLASS parking classes sharing one physical capacity MAX_CAP, each class with its own quota.
- Class-0 quota follows a time-of-day schedule.
- Separate entry and exit request ports are processed every cycle (no multi-cycle state walk per event). Registered occupancy and free-space status drive the gate and display logic.

Parameters:
- NUM_CLASS, 2, number of parking classes (class 0 = general, class 1.. = reserved, e.g. uni).
- CNT_W, 11, width of every count, quota and free value.
- MAX_CAP, 700, total physical spaces; must fit in CNT_W bits.
- TIME_W, 5, width of in_out_time (hour of day, 0..23).
- DEF_QUOTA, 500, reset quota for every class.
- SCHED_EN, 1, 1 = class-0 quota driven by the schedule in RUN; 0 = programmed value only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_out_time  in  TIME_W  current hour.
- cfg_we  in  1  config write strobe (CONFIG state only).
- cfg_class  in  $clog2(NUM_CLASS)  class being configured.
- cfg_quota  in  CNT_W  quota for cfg_class.
- cfg_count  in  CNT_W  initial occupancy for cfg_class.
- cfg_done  in  1  leave CONFIG, enter RUN.
- ent_valid  in  1  car at entry gate.
- ent_class  in  $clog2(NUM_CLASS)  class of the entering car.
- ext_valid  in  1  car at exit gate.
- ext_class  in  $clog2(NUM_CLASS)  class of the exiting car.
- ent_grant  out  1  one-cycle pulse: entry accepted.
- ent_deny  out  1  one-cycle pulse: entry refused, no space.
- ext_err  out  1  one-cycle pulse: exit from an empty class.
- cfg_err  out  1  one-cycle pulse: config write rejected.
- occ  out  NUM_CLASS*CNT_W  per-class parked count, class c at bits [c*CNT_W +: CNT_W].
- free  out  NUM_CLASS*CNT_W  per-class available spaces, same packing.
- total_occ  out  CNT_W  sum of occ.
- full  out  1  total_occ == MAX_CAP.
- ready  out  1  high in RUN.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to CONFIG.
  - All occ = 0, all quota = DEF_QUOTA.
  - All outputs = 0, including ready, full and every pulse.
  - Reset applies mid-operation with no exception; any pending event is dropped.
- FSM states: CONFIG, RUN.
  - CONFIG -> RUN when cfg_done = 1. RUN -> CONFIG only via reset.
- CONFIG:
  - On cfg_we: quota[cfg_class] <= cfg_quota and occ[cfg_class] <= cfg_count.
  - A write is rejected if cfg_count > cfg_quota, or if the new total occupancy exceeds MAX_CAP. On rejection: occ[cfg_class] <= 0, quota is still written, cfg_err pulses for 1 cycle.
  - ent_valid and ext_valid are ignored; no pulses are generated.
  - If cfg_we and cfg_done are both high, the write is applied first, then the FSM moves to RUN.
- Schedule (RUN, SCHED_EN = 1), applied to quota[0]:
  - Hours 9-12 -> 200; 13 -> 250; 14 -> 300; 15 -> 350; all other hours -> 500.
  - Re-evaluated every cycle; other classes keep their programmed quota.
- Free-space rule, computed from registered state:
  - free[c] = min(quota[c] - occ[c], MAX_CAP - total_occ).
  - The quota term saturates at 0 when occ[c] > quota[c] (a schedule drop never evicts cars).
- RUN events, both gates sampled every cycle:
  - Exit is applied first. If occ[ext_class] > 0, decrement it; otherwise set ext_err and leave counts unchanged.
  - Entry is then judged against post-exit counts. If free[ent_class] > 0 after the exit, increment occ and pulse ent_grant; otherwise pulse ent_deny.
  - Consequence: with the lot full, an exit and an entry of the same class in the same cycle produce a grant.
- Latency:
  - grant, deny and err pulses appear the cycle after the request is sampled.
  - occ, free, total_occ and full reflect the event on that same cycle.
  - All outputs are registered.
- Arithmetic: all counts are unsigned CNT_W bits. Increments are guarded by free > 0 and decrements by occ > 0, so no wrap-around can occur.
- Out-of-range class (class index >= NUM_CLASS): the request is treated as deny (entry) or err (exit).

Decomposition:
- Package parking_pkg holds:
  - state enum {CONFIG, RUN};
  - schedule constants (hours 9/13/14/15, quotas 200/250/300/350/500);
  - a function sched_quota(hour) returning CNT_W bits.
- Sub-module parking_class_cnt: one per class, instantiated NUM_CLASS times via generate.
  - Holds quota and occ; takes inc/dec/load strobes; outputs occ and quota-headroom.
  - The top level performs the shared-capacity min, the arbitration and the pulse generation.

Test Plan:
- Reset then cfg class0 (q 500, c 400) and class1 (q 500, c 100), cfg_done, hour 10:
  - ready = 1, occ0 = 400, occ1 = 100, total_occ = 500.
  - free0 = 0 (quota 200 < 400), free1 = 200.
- Config rejection: cfg class1 with count 600 > quota 500 -> cfg_err pulse, occ1 = 0.
- Fill the lot: occ0 = 300, occ1 = 400, hour 16:
  - full = 1; an entry on class1 -> ent_deny, counts unchanged.
  - Simultaneous exit and entry on class1 -> ent_grant, occ1 stays 400, full stays 1.
- Exit from an empty class: occ1 = 0, ext_valid class1 -> ext_err, occ1 stays 0, total_occ unchanged.
- Schedule step at occ0 = 220:
  - Hour 13 -> free0 = 30; hour 12 -> free0 = 0 and an entry is denied; an exit on class0 still decrements to 219.
- Reset mid-RUN with ent_valid high -> next cycle all outputs 0, no ent_grant, state CONFIG.
